// File: rtl/periodic_eval_scheduler_if.sv
// periodic_eval_scheduler_if: event request handshake and per-stream evaluation outputs.
interface periodic_eval_scheduler_if #(
    parameter int NUM_STREAMS = 3,
    parameter int TIME_W = 32
);
    logic ev_valid;
    logic [NUM_STREAMS-1:0] ev_mask;
    logic ev_ready;
    logic [NUM_STREAMS-1:0] enable_out;
    logic [TIME_W-1:0] eval_time;
    logic eval_busy;
    modport master (output ev_valid, ev_mask, input ev_ready, enable_out, eval_time, eval_busy);
    modport slave (input ev_valid, ev_mask, output ev_ready, enable_out, eval_time, eval_busy);
endinterface

// File: rtl/periodic_eval_scheduler.sv
// periodic_eval_scheduler: merges periodic deadlines and events into a queue, then pulses stream enables layer by layer.
// Define SCHED_SKIP_EMPTY_LAYERS_EN to skip layers that hold no stream of the current entry.
module periodic_eval_scheduler #(
    parameter int NUM_STREAMS = 3,
    parameter int NUM_LAYERS = 2,
    parameter logic [2*NUM_STREAMS-1:0] LAYER_MAP = {2'd1, 2'd1, 2'd0},
    parameter int unsigned PERIOD_0 = 4,
    parameter int unsigned PERIOD_1 = 6,
    parameter int unsigned PERIOD_2 = 0,
    parameter int DEPTH = 4,
    parameter int TIME_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    periodic_eval_scheduler_if.slave bus,
    output logic q_push,
    output logic q_push_valid,
    output logic q_pop,
    output logic q_pop_valid,
    output logic overflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, EVAL} state_t;
    function automatic int unsigned period_of(input int i);
        return i == 0 ? PERIOD_0 : i == 1 ? PERIOD_1 : i == 2 ? PERIOD_2 : 32'd0;
    endfunction
    state_t state, state_nxt;
    logic act, full, empty;
    logic [TIME_W-1:0] now, eval_time_q;
    logic [NUM_STREAMS-1:0] due_mask, req, cur_mask, head_mask, en_vec;
    logic [NUM_STREAMS-1:0] mask_mem [DEPTH];
    logic [TIME_W-1:0] time_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [1:0] layer, layer_nxt;
    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_s
        localparam int unsigned P = period_of(i);
        if (P > 0) begin : g_p
            logic [31:0] cnt;
            always_ff @(posedge clk or negedge rst)
                if (!rst) cnt <= P - 1;
                else if (en) cnt <= (cnt == 0) ? P - 1 : cnt - 1;
            assign due_mask[i] = cnt == 0;
        end else begin : g_n
            assign due_mask[i] = 1'b0;
        end
        assign en_vec[i] = act && state == EVAL && cur_mask[i] && LAYER_MAP[2*i+:2] == layer;
    end
    // Reset also gates the combinational strobes so every output reads 0 while rst is low.
    assign act = en & rst;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head_mask = mask_mem[rd_ptr];
    assign req = due_mask | (bus.ev_valid ? bus.ev_mask : '0);
    assign q_push = act & |req;
    assign q_push_valid = q_push & ~full;
    assign bus.ev_ready = act & ~full;
    assign q_pop = act & (state == IDLE);
    assign q_pop_valid = q_pop & ~empty;
    assign bus.enable_out = en_vec;
    assign bus.eval_time = eval_time_q;
    assign bus.eval_busy = state == EVAL;
`ifdef SCHED_SKIP_EMPTY_LAYERS_EN
    function automatic logic [3:0] layers_of(input logic [NUM_STREAMS-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NUM_STREAMS; i++)
            if (m[i]) r[LAYER_MAP[2*i+:2]] = 1'b1;
        return r;
    endfunction
    // Lowest populated layer at or above 'from'; bit 2 set means none left.
    function automatic logic [2:0] next_layer(input logic [3:0] pl, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int l = 3; l >= 0; l--)
            if (pl[l] && l < NUM_LAYERS && 3'(l) >= from) r = 3'(l);
        return r;
    endfunction
    logic [2:0] skip_first, skip_next;
    assign skip_first = next_layer(layers_of(head_mask), 3'd0);
    assign skip_next = next_layer(layers_of(cur_mask), {1'b0, layer} + 3'd1);
    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        if (state == IDLE) begin
            state_nxt = empty ? IDLE : EVAL;
            layer_nxt = empty ? layer : skip_first[1:0];
        end else begin
            state_nxt = skip_next[2] ? IDLE : EVAL;
            layer_nxt = skip_next[1:0];
        end
    end
`else
    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        if (state == IDLE) begin
            state_nxt = empty ? IDLE : EVAL;
            layer_nxt = 2'd0;
        end else begin
            state_nxt = layer == 2'(NUM_LAYERS - 1) ? IDLE : EVAL;
            layer_nxt = layer + 2'd1;
        end
    end
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            layer <= '0;
            now <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            cur_mask <= '0;
            eval_time_q <= '0;
            overflow <= 1'b0;
        end else if (en) begin
            now <= now + 1'b1;
            state <= state_nxt;
            layer <= layer_nxt;
            count <= count + (AW+1)'(q_push_valid) - (AW+1)'(q_pop_valid);
            if (q_push_valid) wr_ptr <= wr_ptr + 1'b1;
            if (q_pop_valid) begin
                rd_ptr <= rd_ptr + 1'b1;
                cur_mask <= head_mask;
                eval_time_q <= time_mem[rd_ptr];
            end
            if (q_push && full && |due_mask) overflow <= 1'b1;
        end
    always_ff @(posedge clk)
        if (q_push_valid) begin
            mask_mem[wr_ptr] <= req;
            time_mem[wr_ptr] <= now;
        end
endmodule

// File: tb/tb_periodic_eval_scheduler.sv
// tb_periodic_eval_scheduler: vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_periodic_eval_scheduler;
    localparam int NS = 3;
    localparam int NL = 2;
    localparam int DEPTH = 4;
    localparam int PER [NS] = '{4, 6, 0};
    localparam int LMAP [NS] = '{0, 1, 1};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic q_push, q_push_valid, q_pop, q_pop_valid, overflow;
    periodic_eval_scheduler_if #(.NUM_STREAMS(NS), .TIME_W(32)) bus ();
    periodic_eval_scheduler dut (
        .clk(clk), .rst(rst), .en(en), .bus(bus.slave),
        .q_push(q_push), .q_push_valid(q_push_valid), .q_pop(q_pop),
        .q_pop_valid(q_pop_valid), .overflow(overflow)
    );
    always #5 clk = ~clk;
    typedef struct packed { logic [2:0] mask; logic [31:0] t; } entry_t;
    typedef struct packed { logic e; logic v; logic [2:0] m; logic qpv; logic popv; logic [2:0] eo; logic busy; logic [7:0] et; } vec_t;
    entry_t mq [$];
    logic [2:0] pend [$];
    logic [31:0] m_time, m_eval_time;
    logic m_ovf;
    int checks = 0;
    int failures = 0;
    vec_t tbl [16];
    function automatic logic [2:0] due_at(input logic [31:0] t);
        logic [2:0] d = '0;
        for (int i = 0; i < NS; i++) if (PER[i] > 0 && (t + 1) % PER[i] == 0) d[i] = 1'b1;
        return d;
    endfunction
    function automatic logic [2:0] layer_streams(input int l);
        logic [2:0] r = '0;
        for (int i = 0; i < NS; i++) if (LMAP[i] == l) r[i] = 1'b1;
        return r;
    endfunction
    function automatic vec_t row(input logic qpv, input logic popv, input logic [2:0] eo, input logic busy, input logic [7:0] et);
        return {1'b1, 1'b0, 3'b000, qpv, popv, eo, busy, et};
    endfunction
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        mq.delete();
        pend.delete();
        m_time = 0;
        m_eval_time = 0;
        m_ovf = 1'b0;
    endtask
    task automatic do_reset();
        en = 1'b0;
        bus.ev_valid = 1'b0;
        bus.ev_mask = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask
    // One clock cycle: drive, compare every output with the model, then advance the model.
    task automatic cycle(input logic e, input logic v, input logic [2:0] m, output logic rdy);
        logic [2:0] due, req, exp_en, lm;
        logic full, idle, qp, qpv, qpop, qpopv;
        entry_t x;
        @(negedge clk);
        en = e;
        bus.ev_valid = v;
        bus.ev_mask = m;
        #1;
        full = mq.size() == DEPTH;
        idle = pend.size() == 0;
        due = e ? due_at(m_time) : 3'b000;
        req = due | (v ? m : 3'b000);
        qp = e && req != 0;
        qpv = qp && !full;
        rdy = e && !full;
        qpop = e && idle;
        qpopv = qpop && mq.size() > 0;
        exp_en = (e && !idle) ? pend[0] : 3'b000;
        chk("strobes", 64'({bus.ev_ready, q_push, q_push_valid, q_pop, q_pop_valid}), 64'({rdy, qp, qpv, qpop, qpopv}));
        chk("enable_out", 64'(bus.enable_out), 64'(exp_en));
        chk("status", 64'({bus.eval_busy, overflow, bus.eval_time}), 64'({!idle, m_ovf, m_eval_time}));
        if (e) begin
            if (qpopv) begin
                x = mq.pop_front();
                m_eval_time = x.t;
                for (int l = 0; l < NL; l++) begin
                    lm = x.mask & layer_streams(l);
`ifdef SCHED_SKIP_EMPTY_LAYERS_EN
                    if (lm != 0)
`endif
                    pend.push_back(lm);
                end
            end else if (!idle) void'(pend.pop_front());
            if (qpv) mq.push_back({req, m_time});
            if (qp && full && due != 0) m_ovf = 1'b1;
            m_time++;
        end
    endtask
    initial begin
        logic rdy, hv, v;
        logic [2:0] hm, m;
        tbl[0] = row(0, 0, 3'b000, 0, 0);   tbl[1] = row(0, 0, 3'b000, 0, 0);
        tbl[2] = row(0, 0, 3'b000, 0, 0);   tbl[3] = row(1, 0, 3'b000, 0, 0);
        tbl[4] = row(0, 1, 3'b000, 0, 0);   tbl[5] = row(1, 0, 3'b001, 1, 3);
        tbl[6] = row(0, 0, 3'b000, 1, 3);   tbl[7] = row(1, 1, 3'b000, 0, 3);
        tbl[8] = row(0, 0, 3'b000, 1, 5);   tbl[9] = row(0, 0, 3'b010, 1, 5);
        tbl[10] = row(0, 1, 3'b000, 0, 5);  tbl[11] = row(1, 0, 3'b001, 1, 7);
        tbl[12] = row(0, 0, 3'b000, 1, 7);  tbl[13] = row(0, 1, 3'b000, 0, 7);
        tbl[14] = row(0, 0, 3'b001, 1, 11); tbl[15] = row(1, 0, 3'b010, 1, 11);
        // Reset state, asserted with en and an event both active.
        #2 rst = 1'b0;
        en = 1'b1;
        bus.ev_valid = 1'b1;
        bus.ev_mask = 3'b111;
        #1;
        chk("reset_outputs", 64'({bus.ev_ready, q_push, q_push_valid, q_pop, q_pop_valid, bus.enable_out, bus.eval_busy, overflow, bus.eval_time}), 64'(0));
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].e, tbl[i].v, tbl[i].m, rdy);
            chk($sformatf("vec%0d", i), 64'({q_push_valid, q_pop_valid, bus.enable_out, bus.eval_busy, bus.eval_time[7:0]}),
                64'({tbl[i].qpv, tbl[i].popv, tbl[i].eo, tbl[i].busy, tbl[i].et}));
        end
        // Event at t=7 merges with the stream-0 deadline.
        do_reset();
        for (int t = 0; t <= 12; t++) begin
            cycle(1'b1, t == 7, t == 7 ? 3'b100 : 3'b000, rdy);
            if (t == 7) chk("merge_push", 64'(q_push_valid), 64'(1));
            if (t == 11) chk("merge_l0", 64'({bus.enable_out, bus.eval_time}), 64'({3'b001, 32'd7}));
            if (t == 12) chk("merge_l1", 64'(bus.enable_out), 64'(3'b100));
        end
        // Event held high fills the queue; a deadline while full sets sticky overflow.
        do_reset();
        for (int t = 0; t <= 20; t++) begin
            cycle(1'b1, 1'b1, 3'b100, rdy);
            if (t == 6 || t == 7) chk("full_drop", 64'({bus.ev_ready, q_push, q_push_valid, overflow}), 64'(4'b0100));
            if (t == 8) chk("overflow_set", 64'({bus.ev_ready, overflow}), 64'(2'b11));
            if (t == 20) chk("overflow_sticky", 64'(overflow), 64'(1));
        end
        // en low for five cycles between layer 0 and layer 1 of entry {011, 11}.
        do_reset();
        for (int t = 0; t <= 14; t++) cycle(1'b1, 1'b0, 3'b000, rdy);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 3'b000, rdy);
            chk("freeze", 64'({q_push, q_pop, bus.enable_out, bus.eval_busy, bus.eval_time}), 64'({2'b00, 3'b000, 1'b1, 32'd11}));
        end
        cycle(1'b1, 1'b0, 3'b000, rdy);
        chk("resume", 64'({bus.enable_out, q_push_valid}), 64'({3'b010, 1'b1}));
        // Asynchronous reset mid-EVAL, between clock edges.
        do_reset();
        for (int t = 0; t <= 5; t++) cycle(1'b1, 1'b0, 3'b000, rdy);
        chk("pre_reset_busy", 64'({bus.enable_out, bus.eval_busy}), 64'({3'b001, 1'b1}));
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset", 64'({bus.enable_out, bus.eval_busy, bus.eval_time, q_pop_valid, overflow}), 64'(0));
        do_reset();
        for (int t = 0; t <= 3; t++) begin
            cycle(1'b1, 1'b0, 3'b000, rdy);
            chk("restart_push", 64'(q_push_valid), 64'(t == 3));
        end
        // Randomized traffic; a refused event is held until accepted.
        do_reset();
        hv = 1'b0;
        hm = '0;
        for (int k = 0; k < 400; k++) begin
            v = hv ? 1'b1 : ($urandom_range(0, 2) == 0);
            m = hv ? hm : 3'($urandom_range(0, 7));
            cycle($urandom_range(0, 9) != 0, v, m, rdy);
            hv = v && !rdy;
            hm = m;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
